mips_regwrite_arbiter: RTL and testbench
========================================

MIPS_REGWRITE_ARBITER -- requirements
Module: mips_regwrite_arbiter

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the dropped-write counter.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 a_valid / a_ready  input / output  1 / 1  SHALL form the handshake for requester A (ALU writeback).
REQ-005 a_reg  input  5  SHALL be A's destination register index; a_data  input  32  SHALL be A's write data.
REQ-006 b_valid / b_ready  input / output  1 / 1  SHALL form the handshake for requester B (load writeback).
REQ-007 b_reg  input  5, b_data  input  32  SHALL be B's index and data.
REQ-008 wr_hold  input  1  SHALL indicate that the register-file write port is unavailable this cycle.
REQ-009 write_reg  output  5, write_data  output  32, signal_reg_write  output  1  SHALL drive the register-file write port.
REQ-010 hz_reg_1, hz_reg_2  input  5  SHALL be the decode-stage read indices checked for hazards.
REQ-011 hz_stall  output  1  SHALL be the hazard indication.
REQ-012 drop_count  output  CNT_W  SHALL be the saturating count of writes to register 0.

Function
REQ-013 The block SHALL hold a one-entry output stage (EMPTY/FULL) with fields reg and data.
REQ-014 Transfer SHALL occur on any edge where valid=1 and ready=1; requesters SHALL hold reg and data stable while valid=1 and ready=0.
REQ-015 can_accept = EMPTY, or FULL with wr_hold=0 (drain and refill in the same cycle).
REQ-016 Grant rules: only one ready asserted per cycle; the sole valid requester wins; if both are valid, the requester named by rr_ptr wins.
REQ-017 a_ready = can_accept and A granted; b_ready likewise for B; ready SHALL not depend combinationally on ready of the other requester.
REQ-018 After each transfer, rr_ptr SHALL point to the non-winner; without a transfer it SHALL be unchanged.
REQ-019 A transfer with reg=0 SHALL complete the handshake, SHALL NOT load the stage, and SHALL increment drop_count, saturating at 2^CNT_W-1.
REQ-020 An accepted transfer with reg!=0 SHALL set the stage FULL; write_reg/write_data SHALL present it the following cycle (latency 1).
REQ-021 signal_reg_write = FULL and wr_hold=0; when this holds at an edge without a new load, the stage SHALL go EMPTY.
REQ-022 While FULL and wr_hold=1, the stage SHALL hold and both ready outputs SHALL be 0.
REQ-023 When EMPTY, write_reg and write_data SHALL read 0.

Reset
REQ-024 rst_n=0 at an edge SHALL set: stage EMPTY, signal_reg_write=0, write_reg=0, write_data=0, rr_ptr=A, drop_count=0.
REQ-025 Reset SHALL assert a_ready=0 and b_ready=0 while rst_n=0.
REQ-026 A FULL stage at reset SHALL be discarded without a write.

Configuration
REQ-027 With MIPS_REGARB_HAZARD_EN defined: hz_stall = FULL and (write_reg==hz_reg_1 or write_reg==hz_reg_2), evaluated combinationally.
REQ-028 Without MIPS_REGARB_HAZARD_EN, the hz_* ports SHALL remain present, with hz_stall tied to 0 and the compare logic absent.

Structure
REQ-029 Package mips_regarb_pkg SHALL hold the following, shared with the datapath:
- REG_IDX_W=5;
- DATA_W=32;
- the requester enum REQ_A/REQ_B;
- the stage-state enum EMPTY/FULL.
REQ-030 The grant logic and rr_ptr SHALL live in sub-module mips_rr_arbiter2; the stage, counter and hazard logic SHALL stay in the top level.

Verification
REQ-031 Reset, then A only: a_valid=1, a_reg=5, a_data=0xDEADBEEF -> next cycle signal_reg_write=1, write_reg=5, write_data=0xDEADBEEF, for one cycle.
REQ-032 Both valid for 3 cycles after reset (A reg 3, B reg 4, new data each cycle) -> grants A,B,A; writes to reg 3,4,3 appear one cycle later.
REQ-033 A valid with a_reg=0 x300 transfers, CNT_W=8 -> no signal_reg_write; drop_count ends at 255.
REQ-034 Stage FULL (reg 7), wr_hold=1 for 4 cycles -> both ready outputs 0, signal_reg_write 0, data held; on release the reg 7 write occurs once.
REQ-035 Stage FULL reg 9, hz_reg_1=9 -> hz_stall=1 with macro, 0 without; rst_n=0 that cycle -> no write issued, all outputs 0.

Source files
------------

// File: rtl/mips_regarb_pkg.sv
// rtl/mips_regarb_pkg.sv - shared widths and enums for the register-write arbiter
package mips_regarb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_e;

endpackage

// File: rtl/mips_rr_arbiter2.sv
// rtl/mips_rr_arbiter2.sv - two-requester round-robin grant with registered pointer
module mips_rr_arbiter2
  import mips_regarb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic can_accept,
  output logic a_ready,
  output logic b_ready
);

  req_e rr_ptr;
  logic grant_a;
  logic grant_b;

  // A sole valid requester wins; on contention the pointer decides.
  // Grants depend only on valids and the pointer, never on the other ready.
  assign grant_a = a_valid && (!b_valid || rr_ptr == REQ_A);
  assign grant_b = b_valid && (!a_valid || rr_ptr == REQ_B);

  assign a_ready = can_accept && grant_a;
  assign b_ready = can_accept && grant_b;

  // Pointer moves to the non-winner after each transfer, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= REQ_A;
    end else if (a_valid && a_ready) begin
      rr_ptr <= REQ_B;
    end else if (b_valid && b_ready) begin
      rr_ptr <= REQ_A;
    end
  end

endmodule

// File: rtl/mips_regwrite_arbiter.sv
// rtl/mips_regwrite_arbiter.sv - ALU/load writeback arbiter with one-entry stage; optional MIPS_REGARB_HAZARD_EN
module mips_regwrite_arbiter
  import mips_regarb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [REG_IDX_W-1:0] a_reg,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [REG_IDX_W-1:0] b_reg,
  input  logic [DATA_W-1:0]    b_data,
  input  logic                 wr_hold,
  output logic [REG_IDX_W-1:0] write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic                 signal_reg_write,
  input  logic [REG_IDX_W-1:0] hz_reg_1,
  input  logic [REG_IDX_W-1:0] hz_reg_2,
  output logic                 hz_stall,
  output logic [CNT_W-1:0]     drop_count
);

  stage_e               state;
  logic [REG_IDX_W-1:0] stage_reg;
  logic [DATA_W-1:0]    stage_data;
  logic                 can_accept;
  logic                 a_xfer;
  logic                 b_xfer;
  logic                 xfer;
  logic [REG_IDX_W-1:0] xfer_reg;
  logic [DATA_W-1:0]    xfer_data;
  logic                 load;
  logic                 drop;

  // Accept when empty, or when full and draining this cycle; never in reset.
  assign can_accept = rst_n && (state == EMPTY || !wr_hold);

  mips_rr_arbiter2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .can_accept (can_accept),
    .a_ready    (a_ready),
    .b_ready    (b_ready)
  );

  assign a_xfer    = a_valid && a_ready;
  assign b_xfer    = b_valid && b_ready;
  assign xfer      = a_xfer || b_xfer;
  assign xfer_reg  = a_xfer ? a_reg  : b_reg;
  assign xfer_data = a_xfer ? a_data : b_data;
  assign load      = xfer && (xfer_reg != '0);
  assign drop      = xfer && (xfer_reg == '0);

  // Stage fields are zeroed whenever empty, so they drive the port directly.
  // Reset gating keeps a stage that is being discarded off the write port.
  assign signal_reg_write = rst_n && (state == FULL) && !wr_hold;
  assign write_reg        = rst_n ? stage_reg  : '0;
  assign write_data       = rst_n ? stage_data : '0;

`ifdef MIPS_REGARB_HAZARD_EN
  assign hz_stall = rst_n && (state == FULL) &&
                    ((stage_reg == hz_reg_1) || (stage_reg == hz_reg_2));
`else
  logic unused_hz;
  assign unused_hz = ^{hz_reg_1, hz_reg_2};
  assign hz_stall  = 1'b0;
`endif

  // Stage load/drain plus saturating count of writes aimed at register 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      stage_reg  <= '0;
      stage_data <= '0;
      drop_count <= '0;
    end else begin
      if (load) begin
        state      <= FULL;
        stage_reg  <= xfer_reg;
        stage_data <= xfer_data;
      end else if (signal_reg_write) begin
        state      <= EMPTY;
        stage_reg  <= '0;
        stage_data <= '0;
      end
      if (drop && drop_count != {CNT_W{1'b1}}) begin
        drop_count <= drop_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_mips_regwrite_arbiter.sv
// tb/tb_mips_regwrite_arbiter.sv - table-driven self-checking bench for mips_regwrite_arbiter
module tb_mips_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, a_ready, b_ready, wr_hold;
  logic [4:0]  a_reg, b_reg, write_reg, hz_reg_1, hz_reg_2;
  logic [31:0] a_data, b_data, write_data;
  logic        signal_reg_write, hz_stall;
  logic [7:0]  drop_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mips_regwrite_arbiter #(.CNT_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .a_reg            (a_reg),
    .a_data           (a_data),
    .b_valid          (b_valid),
    .b_ready          (b_ready),
    .b_reg            (b_reg),
    .b_data           (b_data),
    .wr_hold          (wr_hold),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .signal_reg_write (signal_reg_write),
    .hz_reg_1         (hz_reg_1),
    .hz_reg_2         (hz_reg_2),
    .hz_stall         (hz_stall),
    .drop_count       (drop_count)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  areg;
    logic [31:0] adata;
    logic        bv;
    logic [4:0]  breg;
    logic [31:0] bdata;
    logic        hold;
    logic [4:0]  hz1;
    logic [4:0]  hz2;
    logic        e_ar;
    logic        e_br;
    logic        e_srw;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic        e_hzm;
    logic [7:0]  e_dc;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic hz_exp(input logic m);
`ifdef MIPS_REGARB_HAZARD_EN
    return m;
`else
    return 1'b0 & m;
`endif
  endfunction

  task automatic drive(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic h, input logic [4:0] z1, input logic [4:0] z2);
    @(negedge clk);
    rst_n = r; a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd; wr_hold = h; hz_reg_1 = z1; hz_reg_2 = z2;
    #2;
  endtask

  initial begin
    //          rst av areg adata         bv breg bdata         hld hz1 hz2 | ar br srw wreg wdata          hzm dc
    vecs[0]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0};
    vecs[1]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h0,        0, 0};
    vecs[2]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 5, 0,  0, 0, 1, 5, 32'hDEADBEEF, 1, 0};
    vecs[3]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0};
    vecs[4]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0};
    vecs[5]  = '{1, 1, 3, 32'h11111111, 1, 4, 32'h22222222, 0, 0, 0,  1, 0, 0, 0, 32'h0,        0, 0};
    vecs[6]  = '{1, 1, 3, 32'h33333333, 1, 4, 32'h44444444, 0, 0, 0,  0, 1, 1, 3, 32'h11111111, 0, 0};
    vecs[7]  = '{1, 1, 3, 32'h55555555, 1, 4, 32'h66666666, 0, 0, 0,  1, 0, 1, 4, 32'h44444444, 0, 0};
    vecs[8]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  0, 0, 1, 3, 32'h55555555, 0, 0};
    vecs[9]  = '{1, 1, 0, 32'hABCD,     0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h0,        0, 0};
    vecs[10] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 1};
    vecs[11] = '{1, 0, 0, 32'h0,        1, 7, 32'h77777777, 0, 0, 0,  0, 1, 0, 0, 32'h0,        0, 1};
    vecs[12] = '{1, 1, 8, 32'h88888888, 1, 9, 32'h99999999, 1, 0, 7,  0, 0, 0, 7, 32'h77777777, 1, 1};
    vecs[13] = '{1, 1, 8, 32'h88888888, 1, 9, 32'h99999999, 1, 0, 0,  0, 0, 0, 7, 32'h77777777, 0, 1};
    vecs[14] = '{1, 1, 8, 32'h88888888, 1, 9, 32'h99999999, 0, 0, 0,  1, 0, 1, 7, 32'h77777777, 0, 1};
    vecs[15] = '{1, 0, 0, 32'h0,        1, 9, 32'h99999999, 1, 8, 0,  0, 0, 0, 8, 32'h88888888, 1, 1};
    vecs[16] = '{1, 0, 0, 32'h0,        1, 9, 32'h99999999, 0, 8, 0,  0, 1, 1, 8, 32'h88888888, 1, 1};
    vecs[17] = '{0, 1, 5, 32'h12345678, 0, 0, 32'h0,        0, 9, 0,  0, 0, 0, 0, 32'h0,        0, 1};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].areg, vecs[i].adata, vecs[i].bv, vecs[i].breg,
            vecs[i].bdata, vecs[i].hold, vecs[i].hz1, vecs[i].hz2);
      chk($sformatf("v%0d a_ready", i), {31'b0, a_ready}, {31'b0, vecs[i].e_ar});
      chk($sformatf("v%0d b_ready", i), {31'b0, b_ready}, {31'b0, vecs[i].e_br});
      chk($sformatf("v%0d srw", i), {31'b0, signal_reg_write}, {31'b0, vecs[i].e_srw});
      chk($sformatf("v%0d write_reg", i), {27'b0, write_reg}, {27'b0, vecs[i].e_wreg});
      chk($sformatf("v%0d write_data", i), write_data, vecs[i].e_wdata);
      chk($sformatf("v%0d hz_stall", i), {31'b0, hz_stall}, {31'b0, hz_exp(vecs[i].e_hzm)});
      if (vecs[i].rst) chk($sformatf("v%0d drop_count", i), {24'b0, drop_count}, {24'b0, vecs[i].e_dc});
    end

    // Reset discarded the FULL reg-9 stage: nothing written afterwards.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("post_rst srw", {31'b0, signal_reg_write}, 32'd0);
    chk("post_rst write_reg", {27'b0, write_reg}, 32'd0);
    chk("post_rst drop_count", {24'b0, drop_count}, 32'd0);
    chk("post_rst hz_stall", {31'b0, hz_stall}, 32'd0);

    // 0x300 writes to register 0: handshakes complete, no writes, count saturates.
    for (int i = 0; i < 32'h300; i++) begin
      drive(1, 1, 0, i, 0, 0, 0, 0, 0, 0);
      if (a_ready !== 1'b1 || signal_reg_write !== 1'b0)
        chk($sformatf("drop%0d ready/srw", i), {30'b0, a_ready, signal_reg_write}, 32'd2);
    end
    chk("drop total a_ready last", {31'b0, a_ready}, 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("drop saturated", {24'b0, drop_count}, 32'd255);
    chk("drop no write", {31'b0, signal_reg_write}, 32'd0);

    // Hold a FULL reg-7 stage for four cycles, then release for exactly one write.
    drive(1, 1, 7, 32'hCAFE0007, 0, 0, 0, 0, 0, 0);
    chk("hold load ready", {31'b0, a_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 10, 32'hA0A0A0A0, 1, 11, 32'hB0B0B0B0, 1, 0, 0);
      chk($sformatf("hold%0d a_ready", i), {31'b0, a_ready}, 32'd0);
      chk($sformatf("hold%0d b_ready", i), {31'b0, b_ready}, 32'd0);
      chk($sformatf("hold%0d srw", i), {31'b0, signal_reg_write}, 32'd0);
      chk($sformatf("hold%0d write_data", i), write_data, 32'hCAFE0007);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("release srw", {31'b0, signal_reg_write}, 32'd1);
    chk("release write_reg", {27'b0, write_reg}, 32'd7);
    chk("release write_data", write_data, 32'hCAFE0007);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("after release srw", {31'b0, signal_reg_write}, 32'd0);
    chk("after release write_reg", {27'b0, write_reg}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
